// File: rtl/rng_scheduler.sv
// Seeds a 16-bit XNOR LFSR from a memory word and shares it round-robin
// between requesters, advancing it STEPS positions for every grant.
`timescale 1ns/1ps

module rng_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter logic [15:0] SEED_ADDR  = 16'h07FE,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STEPS      = 4,
    parameter logic [15:0] LOCKUP_SUB = 16'h0005
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            start,
    output logic            mem_rd_en,
    output logic [15:0]     mem_addr,
    input  logic [15:0]     mem_data_out,
    output logic            lfsr_load,
    output logic [15:0]     lfsr_seed,
    output logic            lfsr_shift,
    input  logic [15:0]     lfsr_value,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rand_out,
    output logic            rand_valid,
    output logic            ready
);

    localparam int WW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int N  = int'(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        SEED_RD,
        SEED_WAIT,
        LOAD,
        SERVE,
        STEP,
        DELIVER
    } state_t;

    state_t        state;
    logic [WW-1:0] last_winner;
    logic [WW-1:0] winner;
    logic [3:0]    cnt;
    logic          pending;

    // Closest set bit above last, wrapping; last itself has the lowest priority.
    function automatic logic [WW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                  input logic [WW-1:0]   last);
        logic [WW-1:0] sel;
        int            idx;
        sel = last;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (r[idx]) sel = WW'(idx);
        end
        return sel;
    endfunction

    assign mem_addr = SEED_ADDR;
    assign rand_out = rand_valid ? lfsr_value : 16'h0000;

    // NOTE: every register here, outputs included, is state: non-blocking
    // assignments only, and all of it is cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            last_winner <= WW'(N - 1);
            winner      <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            mem_rd_en   <= 1'b0;
            lfsr_load   <= 1'b0;
            lfsr_seed   <= 16'h0000;
            lfsr_shift  <= 1'b0;
            gnt         <= '0;
            rand_valid  <= 1'b0;
            ready       <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            lfsr_load  <= 1'b0;
            gnt        <= '0;
            rand_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_rd_en <= 1'b1;
                        state     <= SEED_RD;
                    end
                end
                SEED_RD: begin
                    cnt   <= 4'(MEM_LAT - 1);
                    state <= SEED_WAIT;
                end
                SEED_WAIT: begin
                    if (cnt == 4'd0) begin
                        lfsr_seed <= (mem_data_out == 16'hFFFF) ? LOCKUP_SUB : mem_data_out;
                        lfsr_load <= 1'b1;
                        state     <= LOAD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LOAD: begin
                    ready <= 1'b1;
                    state <= SERVE;
                end
                SERVE: begin
                    if (start || pending) begin
                        pending   <= 1'b0;
                        ready     <= 1'b0;
                        mem_rd_en <= 1'b1;
                        state     <= SEED_RD;
                    end else if (|req) begin
                        winner     <= pick_winner(req, last_winner);
                        cnt        <= 4'(STEPS - 1);
                        lfsr_shift <= 1'b1;
                        state      <= STEP;
                    end
                end
                STEP: begin
                    if (start) pending <= 1'b1;
                    if (cnt == 4'd0) begin
                        lfsr_shift  <= 1'b0;
                        gnt[winner] <= 1'b1;
                        rand_valid  <= 1'b1;
                        state       <= DELIVER;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DELIVER: begin
                    if (start) pending <= 1'b1;
                    last_winner <= winner;
                    state       <= SERVE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: memory and LFSR datapath models, a cycle-scheduled
// reference model compared every cycle, and directed literal checks.
`timescale 1ns/1ps

module tb_rng_scheduler;

    localparam int          NREQ       = 4;
    localparam int          MEM_LAT    = 1;
    localparam int          STEPS      = 4;
    localparam logic [15:0] SEED_ADDR  = 16'h07FE;
    localparam logic [15:0] LOCKUP_SUB = 16'h0005;

    logic            clock  = 1'b0;
    logic            nreset = 1'b0;
    logic            start  = 1'b0;
    logic            mem_rd_en;
    logic [15:0]     mem_addr;
    logic [15:0]     mem_data_out;
    logic            lfsr_load;
    logic [15:0]     lfsr_seed;
    logic            lfsr_shift;
    logic [15:0]     lfsr_value;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rand_out;
    logic            rand_valid;
    logic            ready;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] mem_word = 16'h1234;
    logic [3:0]  rd_pipe  = '0;
    logic [15:0] lfsr_q   = 16'h0000;

    rng_scheduler #(
        .NREQ(NREQ), .SEED_ADDR(SEED_ADDR), .MEM_LAT(MEM_LAT),
        .STEPS(STEPS), .LOCKUP_SUB(LOCKUP_SUB)
    ) dut (
        .clock(clock), .nreset(nreset), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_shift(lfsr_shift),
        .lfsr_value(lfsr_value), .req(req), .gnt(gnt), .rand_out(rand_out),
        .rand_valid(rand_valid), .ready(ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ~(q[15] ^ q[14] ^ q[12] ^ q[3])};
    endfunction

    // Memory answers MEM_LAT cycles after the strobe, garbage otherwise; LFSR datapath.
    always @(posedge clock) begin
        rd_pipe <= {rd_pipe[2:0], mem_rd_en};
        if (lfsr_load)       lfsr_q <= lfsr_seed;
        else if (lfsr_shift) lfsr_q <= lfsr_next(lfsr_q);
    end
    assign mem_data_out = rd_pipe[MEM_LAT-1] ? mem_word : 16'hDEAD;
    assign lfsr_value   = lfsr_q;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: activities scheduled by cycle number.
    typedef enum {M_IDLE, M_SEED, M_SERVE, M_GRANT} mact_t;
    mact_t       act    = M_IDLE;
    int          base   = 0;
    int          last_w = NREQ - 1;
    int          win    = 0;
    bit          pend   = 1'b0;
    logic [15:0] m_lfsr = '0;
    logic [15:0] m_seed = '0;
    logic [15:0] m_rand = '0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= NREQ; i++)
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        return 0;
    endfunction

    always @(negedge clock) begin : cmp
        logic            e_rd, e_load, e_shift, e_rdy_known, e_rdy;
        logic [NREQ-1:0] e_gnt;
        logic [15:0]     e_rand;
        logic [15:0]     v;
        if (!nreset) begin
            act = M_IDLE; last_w = NREQ - 1; pend = 1'b0;
            check("rst_mem_rd_en", mem_rd_en, 0);
            check("rst_lfsr_load", lfsr_load, 0);
            check("rst_lfsr_shift", lfsr_shift, 0);
            check("rst_gnt", gnt, 0);
            check("rst_rand_out", rand_out, 0);
            check("rst_ready", ready, 0);
            check("rst_mem_addr", mem_addr, SEED_ADDR);
        end else begin
            e_rd = 0; e_load = 0; e_shift = 0; e_rdy_known = 0; e_rdy = 0;
            e_gnt = '0; e_rand = '0;
            case (act)
                M_IDLE:  e_rdy_known = 1;
                M_SEED: begin
                    e_rd = (cyc == base + 1);
                    e_load = (cyc == base + 2 + MEM_LAT);
                    e_rdy_known = 1;
                end
                M_SERVE: begin e_rdy_known = 1; e_rdy = 1; end
                M_GRANT: begin
                    e_shift = (cyc > base) && (cyc <= base + STEPS);
                    if (cyc == base + STEPS + 1) begin e_gnt[win] = 1'b1; e_rand = m_rand; end
                end
            endcase
            check("mem_addr", mem_addr, SEED_ADDR);
            check("mem_rd_en", mem_rd_en, e_rd);
            check("lfsr_load", lfsr_load, e_load);
            check("lfsr_shift", lfsr_shift, e_shift);
            check("gnt", gnt, e_gnt);
            check("rand_valid", rand_valid, |e_gnt);
            check("rand_out", rand_out, e_rand);
            if (e_rdy_known) check("ready", ready, e_rdy);
            if (e_load) check("lfsr_seed", lfsr_seed, m_seed);

            case (act)
                M_IDLE: if (start) begin
                    act = M_SEED; base = cyc;
                    m_seed = (mem_word == 16'hFFFF) ? LOCKUP_SUB : mem_word;
                end
                M_SEED: if (cyc == base + 2 + MEM_LAT) begin
                    act = M_SERVE; m_lfsr = m_seed;
                end
                M_SERVE: begin
                    if (start || pend) begin
                        pend = 1'b0; act = M_SEED; base = cyc;
                        m_seed = (mem_word == 16'hFFFF) ? LOCKUP_SUB : mem_word;
                    end else if (req != '0) begin
                        win = rr_pick(req, last_w); base = cyc; act = M_GRANT;
                        v = m_lfsr;
                        for (int k = 0; k < STEPS; k++) v = lfsr_next(v);
                        m_rand = v;
                    end
                end
                M_GRANT: begin
                    if (start) pend = 1'b1;
                    if (cyc == base + STEPS + 1) begin
                        last_w = win; m_lfsr = m_rand; act = M_SERVE;
                    end
                end
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_gnt(output logic [NREQ-1:0] g, output logic [15:0] r, output int at);
        g = '0; r = '0; at = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (gnt != '0) begin g = gnt; r = rand_out; at = cyc; break; end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL gnt_timeout at cycle %0d: no grant within 40 cycles", cyc);
        end
    endtask

    task automatic wait_shift();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (lfsr_shift) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL shift_timeout at cycle %0d: no lfsr_shift within 40 cycles", cyc);
        end
    endtask

    initial begin : stim
        logic [NREQ-1:0] g;
        logic [15:0]     r;
        logic [NREQ-1:0] seq [5];
        int              at, prev, t;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        #12;
        check("init_ready", ready, 0);
        check("init_lfsr_seed", lfsr_seed, 16'h0000);
        check("init_rand_valid", rand_valid, 0);
        check("init_mem_addr", mem_addr, 16'h07FE);
        @(posedge clock); #1;
        nreset = 1'b1;

        // Requests before seeding are ignored.
        req = 4'b1111; tick(3);
        req = '0; tick(1);

        start = 1'b1; tick(1); start = 1'b0;
        check("seed_rd_en", mem_rd_en, 1);
        check("seed_addr", mem_addr, 16'h07FE);
        tick(1);
        check("seed_rd_once", mem_rd_en, 0);
        check("seed_no_load_yet", lfsr_load, 0);
        tick(1);
        check("seed_load", lfsr_load, 1);
        check("seed_value", lfsr_seed, 16'h1234);
        tick(1);
        check("seed_ready", ready, 1);
        check("seed_load_once", lfsr_load, 0);

        req = 4'b0100; t = cyc;
        tick(1);
        check("first_shift", lfsr_shift, 1);
        wait_gnt(g, r, at);
        check("gnt_latency", at - t, 5);
        check("gnt_0100", g, 4'b0100);
        check("rand_after_4", r, 16'h2341);

        req = 4'b1000; prev = at;
        wait_gnt(g, r, at);
        check("gnt_1000", g, 4'b1000);
        check("gnt_period", at - prev, 6);

        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            prev = at;
            wait_gnt(g, r, at);
            check("rr_order", g, seq[i]);
            check("rr_period", at - prev, 6);
        end

        // Start during STEP: grant completes, reload follows the next SERVE.
        req = 4'b0010;
        wait_shift();
        mem_word = 16'hFFFF;
        start = 1'b1; tick(1); start = 1'b0;
        wait_gnt(g, r, at);
        check("pend_gnt", g, 4'b0010);
        prev = at;
        tick(1);
        check("pend_serve_ready", ready, 1);
        check("pend_serve_no_rd", mem_rd_en, 0);
        tick(1);
        check("pend_seed_rd", mem_rd_en, 1);
        check("pend_ready_low", ready, 0);
        wait_gnt(g, r, at);
        check("reload_gap", at - prev, 10);
        check("reload_gnt", g, 4'b0010);
        check("lockup_seed", lfsr_seed, 16'h0005);
        check("lockup_rand", r, 16'h005A);

        // Reset in the middle of a STEP sequence.
        wait_shift();
        #2 nreset = 1'b0;
        #1;
        check("abort_shift", lfsr_shift, 0);
        check("abort_gnt", gnt, 0);
        check("abort_rand_valid", rand_valid, 0);
        check("abort_rand_out", rand_out, 0);
        check("abort_ready", ready, 0);
        check("abort_seed", lfsr_seed, 16'h0000);
        check("abort_mem_addr", mem_addr, 16'h07FE);
        repeat (2) @(posedge clock);
        #1;
        nreset = 1'b1;
        mem_word = 16'h1234;
        tick(3);
        check("post_rst_ready", ready, 0);
        check("post_rst_gnt", gnt, 0);
        start = 1'b1; tick(1); start = 1'b0;
        wait_gnt(g, r, at);
        check("post_rst_gnt_sel", g, 4'b0010);
        check("post_rst_rand", r, 16'h2341);

        req = '0;
        tick(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
